trig_conditioner: RTL and testbench

- Two-channel trigger input conditioner that sits directly upstream of the pulse-sequence controller.
- Takes raw asynchronous MKR header trigger pins (main trigger and Rabi-scan trigger) and synchronises them to the 80 MHz internal oscillator clock.
- Rejects glitches and edge-detects each channel, then drives single-cycle, holdoff-protected trigger pulses into the controller's trig/rabi_trig inputs.
- Keeps accepted-trigger and missed-trigger counters for debug.

---
 rtl/trig_conditioner.sv | 198 +++++++++++++++++++
 tb/tb_trig_conditioner.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/trig_conditioner.sv
// Two-channel trigger conditioner: sync, glitch filter, rising-edge
// detect and holdoff-protected one-cycle pulses with debug counters.

module trig_channel #(
    parameter int FILTER_CYCLES  = 8,
    parameter int HOLDOFF_CYCLES = 800,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr_counts,
    input  logic             pin,
    output logic             pulse,
    output logic             hold,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] missed
);

    localparam int FC_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam int TM_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FILTER_CYCLES - 1);
    localparam logic [TM_W-1:0] TM_LOAD = TM_W'(HOLDOFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        HOLDOFF
    } state_t;

    logic            s1;
    logic            s2;
    logic            filt;
    logic            filt_d;
    logic [FC_W-1:0] fc;
    logic            rise;

    state_t          state;
    state_t          state_n;
    logic [TM_W-1:0] timer;
    logic [TM_W-1:0] timer_n;
    logic            pulse_n;
    logic            acc;
    logic            miss;

    // Synchroniser and filter run regardless of en
    always_ff @(posedge clk) begin
        if (rst) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            filt   <= 1'b0;
            filt_d <= 1'b0;
            fc     <= '0;
        end else begin
            s1     <= pin;
            s2     <= s1;
            filt_d <= filt;
            if (s2 == filt) begin
                fc <= '0;
            end else if (fc == FC_LAST) begin
                filt <= s2;
                fc   <= '0;
            end else begin
                fc <= fc + 1'b1;
            end
        end
    end

    assign rise = filt & ~filt_d;

    always_comb begin
        state_n = state;
        timer_n = timer;
        pulse_n = 1'b0;
        acc     = 1'b0;
        miss    = 1'b0;
        if (!en) begin
            state_n = IDLE;
            timer_n = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    state_n = ARMED;
                end
                ARMED: begin
                    if (rise) begin
                        pulse_n = 1'b1;
                        acc     = 1'b1;
                        timer_n = TM_LOAD;
                        state_n = HOLDOFF;
                    end
                end
                HOLDOFF: begin
                    miss = rise;
                    if (timer == '0) begin
                        state_n = ARMED;
                    end else begin
                        timer_n = timer - 1'b1;
                    end
                end
                default: begin
                    state_n = IDLE;
                    timer_n = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            timer <= '0;
            pulse <= 1'b0;
            hold  <= 1'b0;
        end else begin
            state <= state_n;
            timer <= timer_n;
            pulse <= pulse_n;
            hold  <= (state_n == HOLDOFF);
        end
    end

    // Saturating counters; clear beats a same-cycle increment
    always_ff @(posedge clk) begin
        if (rst || clr_counts) begin
            count  <= '0;
            missed <= '0;
        end else begin
            if (acc && count != CNT_MAX) begin
                count <= count + 1'b1;
            end
            if (miss && missed != CNT_MAX) begin
                missed <= missed + 1'b1;
            end
        end
    end

endmodule

module trig_conditioner #(
    parameter int FILTER_CYCLES  = 8,
    parameter int HOLDOFF_CYCLES = 800,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr_counts,
    input  logic             trig_in,
    input  logic             rabi_trig_in,
    output logic             trig_out,
    output logic             rabi_trig_out,
    output logic             busy,
    output logic [CNT_W-1:0] trig_count,
    output logic [CNT_W-1:0] rabi_count,
    output logic [CNT_W-1:0] trig_missed,
    output logic [CNT_W-1:0] rabi_missed
);

    logic main_hold;
    logic rabi_hold;

    trig_channel #(
        .FILTER_CYCLES (FILTER_CYCLES),
        .HOLDOFF_CYCLES(HOLDOFF_CYCLES),
        .CNT_W         (CNT_W)
    ) u_main (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .clr_counts(clr_counts),
        .pin       (trig_in),
        .pulse     (trig_out),
        .hold      (main_hold),
        .count     (trig_count),
        .missed    (trig_missed)
    );

    trig_channel #(
        .FILTER_CYCLES (FILTER_CYCLES),
        .HOLDOFF_CYCLES(HOLDOFF_CYCLES),
        .CNT_W         (CNT_W)
    ) u_rabi (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .clr_counts(clr_counts),
        .pin       (rabi_trig_in),
        .pulse     (rabi_trig_out),
        .hold      (rabi_hold),
        .count     (rabi_count),
        .missed    (rabi_missed)
    );

    assign busy = main_hold | rabi_hold;

endmodule

// File: tb/tb_trig_conditioner.sv
// Directed bench for trig_conditioner: default, short-holdoff and
// narrow-counter instances driven in turn.
`timescale 1ns/1ps

module tb_trig_conditioner;

    logic clk = 1'b0;
    always #6.25 clk = ~clk;

    // Instance a: defaults
    logic rst_a, en_a, clr_a, trig_a, rabi_a;
    logic to_a, ro_a, busy_a;
    logic [15:0] tc_a, rc_a, tm_a, rm_a;

    // Instance b: HOLDOFF_CYCLES = 100
    logic rst_b, en_b, clr_b, trig_b, rabi_b;
    logic to_b, ro_b, busy_b;
    logic [15:0] tc_b, rc_b, tm_b, rm_b;

    // Instance c: CNT_W = 4, short holdoff
    logic rst_c, en_c, clr_c, trig_c, rabi_c;
    logic to_c, ro_c, busy_c;
    logic [3:0] tc_c, rc_c, tm_c, rm_c;

    trig_conditioner dut_a (
        .clk(clk), .rst(rst_a), .en(en_a), .clr_counts(clr_a),
        .trig_in(trig_a), .rabi_trig_in(rabi_a),
        .trig_out(to_a), .rabi_trig_out(ro_a), .busy(busy_a),
        .trig_count(tc_a), .rabi_count(rc_a),
        .trig_missed(tm_a), .rabi_missed(rm_a)
    );

    trig_conditioner #(.HOLDOFF_CYCLES(100)) dut_b (
        .clk(clk), .rst(rst_b), .en(en_b), .clr_counts(clr_b),
        .trig_in(trig_b), .rabi_trig_in(rabi_b),
        .trig_out(to_b), .rabi_trig_out(ro_b), .busy(busy_b),
        .trig_count(tc_b), .rabi_count(rc_b),
        .trig_missed(tm_b), .rabi_missed(rm_b)
    );

    trig_conditioner #(.HOLDOFF_CYCLES(4), .CNT_W(4)) dut_c (
        .clk(clk), .rst(rst_c), .en(en_c), .clr_counts(clr_c),
        .trig_in(trig_c), .rabi_trig_in(rabi_c),
        .trig_out(to_c), .rabi_trig_out(ro_c), .busy(busy_c),
        .trig_count(tc_c), .rabi_count(rc_c),
        .trig_missed(tm_c), .rabi_missed(rm_c)
    );

    int cyc = 0;
    int np_a = 0, nr_a = 0, nb_a = 0, np_b = 0, np_c = 0;
    int last_a = 0, lastr_a = 0;
    int n_chk = 0, n_fail = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (to_a) begin np_a++; last_a = cyc; end
        if (ro_a) begin nr_a++; lastr_a = cyc; end
        if (busy_a) nb_a++;
        if (to_b) np_b++;
        if (to_c) np_c++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    int t0, p0, b0;

    initial begin
        {rst_a, rst_b, rst_c} = 3'b111;
        {en_a, en_b, en_c} = 3'b000;
        {clr_a, clr_b, clr_c} = 3'b000;
        {trig_a, rabi_a, trig_b, rabi_b, trig_c, rabi_c} = 6'b0;
        tick(2);

        chk("rst_trig_out", to_a, 0);
        chk("rst_rabi_out", ro_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_trig_count", tc_a, 0);
        chk("rst_rabi_count", rc_a, 0);
        chk("rst_trig_missed", tm_a, 0);
        chk("rst_rabi_missed", rm_a, 0);

        {rst_a, rst_b, rst_c} = 3'b000;
        {en_a, en_b, en_c} = 3'b111;
        tick(2);

        // Clean trigger, 20 cycles high
        t0 = cyc;
        p0 = np_a;
        b0 = nb_a;
        trig_a = 1'b1;
        tick(20);
        trig_a = 1'b0;
        tick(850);
        chk("clean_pulses", np_a - p0, 1);
        chk("clean_latency", last_a - t0, 11);
        chk("clean_rabi_quiet", nr_a, 0);
        chk("clean_count", tc_a, 1);
        chk("clean_busy_cycles", nb_a - b0, 800);

        // Glitch rejection: 7 high rejected, 8 high accepted
        rst_a = 1'b1;
        tick(1);
        rst_a = 1'b0;
        tick(2);
        p0 = np_a;
        trig_a = 1'b1;
        tick(7);
        trig_a = 1'b0;
        tick(20);
        chk("glitch7_pulses", np_a - p0, 0);
        chk("glitch7_count", tc_a, 0);
        trig_a = 1'b1;
        tick(8);
        trig_a = 1'b0;
        tick(20);
        chk("glitch8_pulses", np_a - p0, 1);
        chk("glitch8_count", tc_a, 1);

        // Independence: both pins on the same edge
        tick(850);
        rst_a = 1'b1;
        tick(1);
        rst_a = 1'b0;
        tick(2);
        p0 = np_a;
        trig_a = 1'b1;
        rabi_a = 1'b1;
        tick(20);
        trig_a = 1'b0;
        rabi_a = 1'b0;
        tick(5);
        chk("indep_main_pulses", np_a - p0, 1);
        chk("indep_rabi_pulses", nr_a, 1);
        chk("indep_same_cycle", lastr_a, last_a);
        chk("indep_trig_count", tc_a, 1);
        chk("indep_rabi_count", rc_a, 1);
        tick(850);

        // en dropped mid-holdoff, re-enabled with pin still high
        p0 = np_a;
        trig_a = 1'b1;
        tick(11);
        chk("en_pulse", to_a, 1);
        tick(30);
        chk("en_busy_before", busy_a, 1);
        en_a = 1'b0;
        tick(1);
        chk("en_busy_drop", busy_a, 0);
        tick(5);
        en_a = 1'b1;
        tick(30);
        chk("reen_no_pulse", np_a - p0, 1);
        chk("reen_count", tc_a, 2);
        chk("reen_missed", tm_a, 0);

        // Reset in holdoff
        trig_a = 1'b0;
        tick(20);
        trig_a = 1'b1;
        tick(11);
        chk("rsth_pulse", to_a, 1);
        tick(30);
        rst_a = 1'b1;
        tick(1);
        chk("rsth_trig_out", to_a, 0);
        chk("rsth_busy", busy_a, 0);
        chk("rsth_trig_count", tc_a, 0);
        chk("rsth_rabi_count", rc_a, 0);
        chk("rsth_trig_missed", tm_a, 0);
        rst_a = 1'b0;
        trig_a = 1'b0;
        tick(2);

        // Holdoff 100: edges at t=0, 50, 200
        trig_b = 1'b1; tick(10); trig_b = 1'b0; tick(40);
        trig_b = 1'b1; tick(10); trig_b = 1'b0; tick(140);
        trig_b = 1'b1; tick(10); trig_b = 1'b0; tick(150);
        chk("hold_pulses", np_b, 2);
        chk("hold_count", tc_b, 2);
        chk("hold_missed", tm_b, 1);

        // 4-bit counter saturation, then clear vs accept
        for (int i = 0; i < 17; i++) begin
            trig_c = 1'b1;
            tick(10);
            trig_c = 1'b0;
            tick(15);
        end
        chk("sat_pulses", np_c, 17);
        chk("sat_count", tc_c, 15);
        trig_c = 1'b1;
        tick(10);
        clr_c = 1'b1;
        tick(1);
        chk("clr_accept_pulse", to_c, 1);
        chk("clr_wins", tc_c, 0);
        clr_c = 1'b0;
        tick(1);
        chk("clr_hold", tc_c, 0);
        trig_c = 1'b0;
        tick(5);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
